// File: rtl/sni_rx_frame_checker.sv
// SNI receive frame checker: pops {eod, byte} FIFO entries, checks CRC-32 and length,
// strips the FCS and streams the payload over valid/ready with an error code on the last beat.
module sni_rx_frame_checker #(
    parameter bit BIT_REVERSE = 1'b1,
    parameter int MIN_FRAME   = 64,
    parameter int MAX_FRAME   = 1518
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_EOD_out,
    output logic       fifo_rden,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic [2:0] m_err,
    output logic       stat_frame_ok,
    output logic       stat_frame_err
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] err;
    } beat_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    state_t      state, state_nxt;
    logic        rd_pend;
    logic [7:0]  b;
    logic [31:0] crc, crc_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [7:0]  dl [4];
    beat_t       sk0, sk1, nb;
    logic [1:0]  sk_cnt, sk_after;
    logic        byte_v, eod_now, push, pop, last_pop, delay_free;
    logic        crc_bad, runt, giant;
    logic        stat_ok_nxt, stat_err_nxt;

    assign byte_v  = rd_pend;
    assign eod_now = byte_v & fifo_EOD_out;

    always_comb begin
        b = fifo_dout;
        if (BIT_REVERSE)
            for (int i = 0; i < 8; i++) b[i] = fifo_dout[7-i];
    end

    assign crc_nxt = crc_byte((state == S_IDLE) ? CRC_INIT : crc, b);
    assign cnt_nxt = (state == S_IDLE) ? 11'd1 : ((cnt == 11'h7FF) ? cnt : cnt + 11'd1);
    assign crc_bad = (crc_nxt != CRC_RESIDUE);
    assign runt    = (cnt_nxt < MIN_LEN);
    assign giant   = (cnt_nxt > MAX_LEN);

    assign m_valid  = (sk_cnt != 2'd0);
    assign m_data   = sk0.data;
    assign m_last   = m_valid & sk0.last;
    assign m_err    = m_last ? sk0.err : 3'b000;
    assign pop      = m_valid & m_ready;
    assign last_pop = (state == S_DONE) & pop & sk0.last;

    assign push     = byte_v & (state == S_STREAM);
    assign nb       = '{data: dl[3], last: fifo_EOD_out,
                        err: fifo_EOD_out ? {giant, runt, crc_bad} : 3'b000};
    assign sk_after = sk_cnt + {1'b0, push} - {1'b0, pop};

    // A read lands next cycle: it needs either a delay-line entry that pushes nothing out,
    // or a skid entry that stays free even if m_ready drops.
    assign delay_free = (state == S_IDLE) ||
                        ((state == S_FILL) && ((cnt[2:0] + {2'b00, byte_v}) < 3'd4));
    assign fifo_rden  = !fifo_empty && !eod_now &&
                        ((state != S_DONE) || last_pop) &&
                        (delay_free || (sk_after <= 2'd1));

    // NOTE: defaults are assigned before the case so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        stat_ok_nxt  = 1'b0;
        stat_err_nxt = 1'b0;
        case (state)
            S_IDLE: if (byte_v) begin
                if (fifo_EOD_out) stat_err_nxt = 1'b1;
                else              state_nxt    = S_FILL;
            end
            S_FILL: if (byte_v) begin
                if (fifo_EOD_out) begin
                    stat_err_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end else if (cnt_nxt == 11'd4) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: if (eod_now) state_nxt = S_DONE;
            S_DONE: if (last_pop) begin
                stat_ok_nxt  = (sk0.err == 3'b000);
                stat_err_nxt = (sk0.err != 3'b000);
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_pend        <= 1'b0;
            crc            <= CRC_INIT;
            cnt            <= '0;
            sk_cnt         <= '0;
            sk0            <= '0;
            sk1            <= '0;
            stat_frame_ok  <= 1'b0;
            stat_frame_err <= 1'b0;
        end else begin
            rd_pend        <= fifo_rden;
            stat_frame_ok  <= stat_ok_nxt;
            stat_frame_err <= stat_err_nxt;
            if (byte_v) begin
                crc <= crc_nxt;
                cnt <= cnt_nxt;
            end
            sk_cnt <= sk_after;
            if (push && !pop) begin
                if (sk_cnt == 2'd0) sk0 <= nb;
                else                sk1 <= nb;
            end else if (!push && pop) begin
                sk0 <= sk1;
            end else if (push && pop) begin
                if (sk_cnt == 2'd1) begin
                    sk0 <= nb;
                end else begin
                    sk0 <= sk1;
                    sk1 <= nb;
                end
            end
        end
    end

    // NOTE: the delay line is data-only storage; its occupancy lives in state/cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (byte_v) begin
            dl[0] <= b;
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
        end
    end

endmodule
